sram_bus_master: RTL and testbench

- Synchronous initiator for an 8Kx8 asynchronous SRAM of the TMM2064P/CY6264 class.
- Converts a single-clock request/acknowledge host port into device pin sequencing: CE, OE, WE, address, and a split data bus with tristate enable.
- The bus is resolved at the top level.
- Access timing is set in clock cycles by parameters so that device tAA, write-pulse and OE-to-high-Z limits are met at the system clock rate.

---
 rtl/sram_bus_master_if.sv | 45 ++++
 rtl/sram_bus_master.sv | 178 +++++++++++++++++
 tb/tb_sram_bus_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_master_if.sv
// rtl/sram_bus_master_if.sv - host and SRAM pin bundle for sram_bus_master
//
// Purpose: groups the host request/acknowledge port and the SRAM pin
// sequencing signals of sram_bus_master into one bundle.
//
// Signals:
//   REQ, WR, ADDR, WDATA   host request, direction, address, write data
//   READY, ACK, RDATA      controller idle, completion pulse, read data
//   A, CE_n, OE_n, WE_n    SRAM address and active-low strobes
//   D_OUT, D_OE, D_IN      split SRAM data bus: drive value, drive enable,
//                          value read back from the resolved bus
//
// Modports:
//   master  controller view (drives READY/ACK/RDATA and the SRAM pins)
//   slave   host plus SRAM view (drives requests and D_IN)

interface sram_bus_master_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              REQ;
   logic              WR;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic              READY;
   logic              ACK;
   logic [DATA_W-1:0] RDATA;
   logic [ADDR_W-1:0] A;
   logic              CE_n;
   logic              OE_n;
   logic              WE_n;
   logic [DATA_W-1:0] D_OUT;
   logic              D_OE;
   logic [DATA_W-1:0] D_IN;

   modport master (
      input  REQ, WR, ADDR, WDATA, D_IN,
      output READY, ACK, RDATA, A, CE_n, OE_n, WE_n, D_OUT, D_OE
   );

   modport slave (
      output REQ, WR, ADDR, WDATA, D_IN,
      input  READY, ACK, RDATA, A, CE_n, OE_n, WE_n, D_OUT, D_OE
   );
endinterface

// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - synchronous initiator for an 8Kx8 asynchronous SRAM
//
// Purpose: turns a single-clock request/acknowledge host port into CE/OE/WE
// pin sequencing with a split data bus. Access lengths are counted in clock
// cycles (RD_WAIT, WR_WAIT, TURN_CYCLES) so device tAA, write-pulse width and
// OE-to-high-Z are met at the system clock rate. Every output is a flop.
//
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous reset, active-high; aborts any access in flight
//   bus   sram_bus_master_if.master (host handshake and SRAM pins)

module sram_bus_master #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int RD_WAIT     = 10,
   parameter int WR_WAIT     = 6,
   parameter int TURN_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic              CLK,
   input  logic              RST,
   sram_bus_master_if.master bus
);

   // A wait of 0 would leave no cycle for the strobe, so it is stretched to 1.
   localparam int RD_EFF = (RD_WAIT < 1) ? 1 : RD_WAIT;
   localparam int WR_EFF = (WR_WAIT < 1) ? 1 : WR_WAIT;
   localparam int TN_EFF = (TURN_CYCLES < 1) ? 1 : TURN_CYCLES;

   // The counter is loaded with length-1 on state entry and the state is left
   // when it reads 0, so the state lasts exactly `length` cycles.
   localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_EFF - 1);
   localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_EFF - 1);
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TN_EFF - 1);
   localparam bit               HAS_TURN  = (TURN_CYCLES > 0);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACC,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE,
      TURN
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              is_rd;
   logic              ready_q;
   logic              ack_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] dout_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic              d_oe_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         is_rd   <= 1'b0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         a_q     <= '0;
         dout_q  <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         d_oe_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            IDLE: begin
               // READY is raised one cycle after reset or on return here, so
               // a request is only ever taken while READY is visibly high.
               if (ready_q && bus.REQ) begin
                  ready_q <= 1'b0;
                  a_q     <= bus.ADDR;
                  dout_q  <= bus.WDATA;
                  is_rd   <= ~bus.WR;
                  ce_n_q  <= 1'b0;
                  if (bus.WR) begin
                     d_oe_q <= 1'b1;
                     state  <= WR_SETUP;
                  end else begin
                     oe_n_q <= 1'b0;
                     cnt    <= RD_LOAD;
                     state  <= RD_ACC;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end

            RD_ACC: begin
               if (cnt == '0) begin
                  // Sample the bus on the same edge that releases OE_n/CE_n.
                  rdata_q <= bus.D_IN;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  ack_q   <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            WR_SETUP: begin
               // Address and data have settled for a cycle before WE_n falls.
               we_n_q <= 1'b0;
               cnt    <= WR_LOAD;
               state  <= WR_PULSE;
            end

            WR_PULSE: begin
               if (cnt == '0) begin
                  we_n_q <= 1'b1;
                  state  <= WR_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            WR_HOLD: begin
               // Data stays driven one cycle past the WE_n rising edge.
               ce_n_q <= 1'b1;
               d_oe_q <= 1'b0;
               ack_q  <= 1'b1;
               state  <= DONE;
            end

            DONE: begin
               if (is_rd && HAS_TURN) begin
                  cnt   <= TURN_LOAD;
                  state <= TURN;
               end else begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end

            TURN: begin
               // Lets the SRAM stop driving after OE_n before any write drives.
               if (cnt == '0) begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               ce_n_q <= 1'b1;
               oe_n_q <= 1'b1;
               we_n_q <= 1'b1;
               d_oe_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.READY = ready_q;
   assign bus.ACK   = ack_q;
   assign bus.RDATA = rdata_q;
   assign bus.A     = a_q;
   assign bus.D_OUT = dout_q;
   assign bus.CE_n  = ce_n_q;
   assign bus.OE_n  = oe_n_q;
   assign bus.WE_n  = we_n_q;
   assign bus.D_OE  = d_oe_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// tb/tb_sram_bus_master.sv - directed self-checking bench for sram_bus_master

module tb_sram_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0;
   logic rst1;

   sram_bus_master_if #(.ADDR_W(13), .DATA_W(8)) b0 ();
   sram_bus_master_if #(.ADDR_W(13), .DATA_W(8)) b1 ();

   sram_bus_master #(
      .ADDR_W(13), .DATA_W(8), .RD_WAIT(10), .WR_WAIT(6), .TURN_CYCLES(4), .CNT_W(8)
   ) dut0 (
      .CLK(clk), .RST(rst0), .bus(b0.master)
   );

   sram_bus_master #(
      .ADDR_W(13), .DATA_W(8), .RD_WAIT(1), .WR_WAIT(1), .TURN_CYCLES(0), .CNT_W(8)
   ) dut1 (
      .CLK(clk), .RST(rst1), .bus(b1.master)
   );

   // SRAM models: write while CE_n and WE_n are low, read while CE_n and OE_n are low.
   logic [7:0] mem0 [0:8191];
   logic [7:0] mem1 [0:8191];

   always @(posedge clk) begin
      if (!b0.CE_n && !b0.WE_n) mem0[b0.A] <= b0.D_OE ? b0.D_OUT : 8'hEE;
      if (!b1.CE_n && !b1.WE_n) mem1[b1.A] <= b1.D_OE ? b1.D_OUT : 8'hEE;
   end

   assign b0.D_IN = (!b0.CE_n && !b0.OE_n) ? mem0[b0.A] : 8'hA5;
   assign b1.D_IN = (!b1.CE_n && !b1.OE_n) ? mem1[b1.A] : 8'hA5;

   // Pin-level monitors
   int contention = 0;
   int we_bad     = 0;
   int unstable   = 0;
   int ack0_cnt   = 0;
   int ack1_cnt   = 0;
   logic        pw0 = 1'b0;
   logic [12:0] pa0 = '0;
   logic [7:0]  pd0 = '0;

   always @(negedge clk) begin
      if (b0.D_OE && !b0.OE_n) contention++;
      if (b1.D_OE && !b1.OE_n) contention++;
      if (!b0.WE_n && (b0.CE_n || !b0.D_OE)) we_bad++;
      if (!b1.WE_n && (b1.CE_n || !b1.D_OE)) we_bad++;
      if (b0.ACK) ack0_cnt++;
      if (b1.ACK) ack1_cnt++;
      if (pw0 && !b0.CE_n && b0.D_OE && ((b0.A !== pa0) || (b0.D_OUT !== pd0))) unstable++;
      pw0 = !b0.CE_n && b0.D_OE;
      pa0 = b0.A;
      pd0 = b0.D_OUT;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int which, input logic req, input logic wr,
                        input logic [12:0] addr, input logic [7:0] wdata);
      if (which == 0) begin
         b0.REQ = req; b0.WR = wr; b0.ADDR = addr; b0.WDATA = wdata;
      end else begin
         b1.REQ = req; b1.WR = wr; b1.ADDR = addr; b1.WDATA = wdata;
      end
   endtask

   // One access; cycle n counts negedges after the accept edge (first = 1).
   task automatic access(input int which, input logic wr, input logic [12:0] addr,
                         input logic [7:0] wdata, input bit poke,
                         output int ack_cyc, output int rdy_cyc, output logic [7:0] rdata,
                         output int we_low, output int oe_low);
      int guard;
      ack_cyc = -1; rdy_cyc = -1; rdata = '0; we_low = 0; oe_low = 0;
      guard = 0;
      while (!((which == 0) ? b0.READY : b1.READY) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      drive(which, 1'b1, wr, addr, wdata);
      @(negedge clk);
      drive(which, 1'b0, ~wr, ~addr, ~wdata);
      for (int n = 1; n <= 200; n++) begin
         if (poke && n == 1) drive(which, 1'b1, ~wr, ~addr, ~wdata);
         if (poke && n == 2) drive(which, 1'b0, ~wr, ~addr, ~wdata);
         if ((which == 0) ? b0.ACK : b1.ACK) begin
            ack_cyc = n;
            rdata   = (which == 0) ? b0.RDATA : b1.RDATA;
         end
         if (!((which == 0) ? b0.WE_n : b1.WE_n)) we_low++;
         if (!((which == 0) ? b0.OE_n : b1.OE_n)) oe_low++;
         if ((which == 0) ? b0.READY : b1.READY) begin
            rdy_cyc = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_c, rdy_c, we_l, oe_l, base, guard;
      logic [7:0] rd;
      logic [7:0] shadow [0:3];
      logic [7:0] exp_rd;
      logic       wr_i;
      int         k;

      for (int i = 0; i < 8192; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end
      for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
      drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
      drive(1, 1'b0, 1'b0, 13'h0, 8'h0);
      rst0 = 1'b1;
      rst1 = 1'b1;

      // Reset then idle
      repeat (3) @(negedge clk);
      check("rst_ready", b0.READY, 0);
      check("rst_ce_n",  b0.CE_n,  1);
      check("rst_oe_n",  b0.OE_n,  1);
      check("rst_we_n",  b0.WE_n,  1);
      check("rst_d_oe",  b0.D_OE,  0);
      check("rst_a",     b0.A,     0);
      check("rst_d_out", b0.D_OUT, 0);
      check("rst_rdata", b0.RDATA, 0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);
      check("ready_after_rst",  b0.READY, 1);
      check("ready_after_rst1", b1.READY, 1);
      repeat (3) @(negedge clk);
      check("idle_no_ack", ack0_cnt, 0);
      check("idle_ce_n",   b0.CE_n,  1);

      // Write then read, default timing
      access(0, 1'b1, 13'h1ABC, 8'h5A, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("wr_we_low", we_l, 6);
      check("wr_ack",    ack_c, 9);
      check("wr_ready",  rdy_c, 10);
      check("wr_oe_low", oe_l, 0);
      access(0, 1'b0, 13'h1ABC, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("rd_oe_low", oe_l, 10);
      check("rd_ack",    ack_c, 11);
      check("rd_data",   rd, 8'h5A);
      check("rd_ready",  rdy_c, 16);
      check("rd_we_low", we_l, 0);

      // Address extremes, no aliasing
      access(0, 1'b1, 13'h1FFF, 8'hFF, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      access(0, 1'b1, 13'h0000, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      access(0, 1'b0, 13'h1FFF, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("wrap_rd_1fff", rd, 8'hFF);
      access(0, 1'b0, 13'h0000, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("wrap_rd_0000", rd, 8'h00);

      // 20 alternating accesses with REQ held high
      base = ack0_cnt;
      for (int i = 0; i < 20; i++) begin
         guard = 0;
         while (!b0.READY && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         wr_i = ((i % 2) == 0);
         k = wr_i ? ((i / 2) % 4) : (((i / 2) + 3) % 4);
         exp_rd = shadow[k];
         drive(0, 1'b1, wr_i, 13'h0200 + 13'(k), 8'h40 + 8'(i));
         if (wr_i) shadow[k] = 8'h40 + 8'(i);
         @(negedge clk);
         guard = 0;
         while (!b0.ACK && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (!wr_i) check($sformatf("burst_rd_%0d", i), b0.RDATA, exp_rd);
      end
      drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
      repeat (20) @(negedge clk);
      check("burst_ack_count", ack0_cnt - base, 20);

      // Reset in the middle of a write pulse
      base = ack0_cnt;
      drive(0, 1'b1, 1'b1, 13'h0555, 8'h77);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
      @(negedge clk);
      check("mid_we_low", b0.WE_n, 0);
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      check("mid_rst_we_n",  b0.WE_n,  1);
      check("mid_rst_ce_n",  b0.CE_n,  1);
      check("mid_rst_d_oe",  b0.D_OE,  0);
      check("mid_rst_ack",   b0.ACK,   0);
      check("mid_rst_ready", b0.READY, 0);
      rst0 = 1'b0;
      repeat (12) @(negedge clk);
      check("mid_rst_no_ack", ack0_cnt - base, 0);
      access(0, 1'b1, 13'h0666, 8'h99, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("post_rst_wr_ack",   ack_c, 9);
      check("post_rst_wr_ready", rdy_c, 10);
      access(0, 1'b0, 13'h0666, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("post_rst_rd_data", rd, 8'h99);

      // Minimum timing instance, with a request poked while busy
      base = ack1_cnt;
      access(1, 1'b1, 13'h0010, 8'hC3, 1'b1, ack_c, rdy_c, rd, we_l, oe_l);
      check("min_wr_ack",    ack_c, 4);
      check("min_wr_ready",  rdy_c, 5);
      check("min_wr_we_low", we_l, 1);
      repeat (3) @(negedge clk);
      check("min_busy_ignored_ready", b1.READY, 1);
      check("min_busy_ignored_acks",  ack1_cnt - base, 1);
      access(1, 1'b0, 13'h0010, 8'h00, 1'b0, ack_c, rdy_c, rd, we_l, oe_l);
      check("min_rd_ack",    ack_c, 2);
      check("min_rd_ready",  rdy_c, 3);
      check("min_rd_data",   rd, 8'hC3);
      check("min_rd_oe_low", oe_l, 1);

      // Pin invariants over the whole run
      check("no_contention",   contention, 0);
      check("we_only_driving", we_bad, 0);
      check("write_stable",    unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
